// File: rtl/axi4_pkg.sv
// Shared AXI4 types and constants for the burst master.
package axi4_pkg;

  // Burst master FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    DONE    = 3'd6
  } axi_mst_state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AxSIZE encoding: log2 of the data-bus width in bytes.
  function automatic logic [2:0] size_of(input int unsigned data_width);
    logic [2:0] sz;
    case (data_width)
      8:       sz = 3'd0;
      16:      sz = 3'd1;
      32:      sz = 3'd2;
      64:      sz = 3'd3;
      128:     sz = 3'd4;
      default: sz = 3'd2;
    endcase
    return sz;
  endfunction

endpackage : axi4_pkg

// File: rtl/axi4_burst_master.sv
// AXI4 initiator issuing single-outstanding INCR bursts from a command port.
// Optional build macro: AXI_BURST_MASTER_STATS_EN adds burst/error counters.
import axi4_pkg::*;

module axi4_burst_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  // command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [7:0]                cmd_len,
  // write-beat stream
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  // read-beat stream
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_last,
  // AXI write address
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic [7:0]                AWLEN,
  output logic [2:0]                AWSIZE,
  output logic [1:0]                AWBURST,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  // AXI write data
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WLAST,
  output logic                      WVALID,
  input  logic                      WREADY,
  // AXI write response
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  // AXI read address
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  // AXI read data
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY,
  // completion
  output logic                      done,
  output logic [1:0]                done_resp,
`ifdef AXI_BURST_MASTER_STATS_EN
  output logic                      done_err,
  output logic [15:0]               stat_bursts,
  output logic [15:0]               stat_errs
`else
  output logic                      done_err
`endif
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  axi_mst_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [1:0]              resp_q, resp_d;
  logic                    err_q, err_d;

  // Address channels come straight from the burst registers so they stay stable.
  assign AWADDR    = addr_q;
  assign AWLEN     = len_q;
  assign AWSIZE    = size_of(DATA_WIDTH);
  assign AWBURST   = BURST_INCR;
  assign ARADDR    = addr_q;
  assign ARLEN     = len_q;
  assign ARSIZE    = size_of(DATA_WIDTH);
  assign ARBURST   = BURST_INCR;
  assign WDATA     = wr_data;
  assign WSTRB     = {STRB_WIDTH{1'b1}};
  assign rd_data   = RDATA;
  assign done_resp = resp_q;
  assign done_err  = err_q;

  // State and burst bookkeeping registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= RESP_OKAY;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  // Next-state, beat counting, response accumulation and channel handshakes.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    wr_ready  = 1'b0;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = cmd_len;
          resp_d  = RESP_OKAY;
          err_d   = 1'b0;
          state_d = cmd_write ? WR_ADDR : RD_ADDR;
        end
      end

      WR_ADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) state_d = WR_DATA;
      end

      WR_DATA: begin
        WVALID   = wr_valid;
        wr_ready = WREADY;
        WLAST    = (cnt_q == 8'd0);
        if (wr_valid && WREADY) begin
          if (cnt_q == 8'd0) state_d = WR_RESP;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end

      WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID) begin
          resp_d  = BRESP;
          state_d = DONE;
        end
      end

      RD_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = RD_DATA;
      end

      RD_DATA: begin
        rd_valid = RVALID;
        RREADY   = rd_ready;
        rd_last  = RLAST;
        if (RVALID && rd_ready) begin
          if (RRESP > resp_q) resp_d = RRESP;
          if (cnt_q != 8'd0)  cnt_d  = cnt_q - 8'd1;
          if (RLAST) begin
            // early RLAST is flagged but still terminates the burst
            if (cnt_q != 8'd0) err_d = 1'b1;
            state_d = DONE;
          end else if (cnt_q == 8'd0) begin
            // slave overran the burst length; keep draining until RLAST
            err_d = 1'b1;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef AXI_BURST_MASTER_STATS_EN
  logic [15:0] stat_bursts_q;
  logic [15:0] stat_errs_q;
  logic        burst_bad;

  assign burst_bad   = (resp_q >= RESP_SLVERR) || err_q;
  assign stat_bursts = stat_bursts_q;
  assign stat_errs   = stat_errs_q;

  // Saturating burst and error counters, bumped on each completion.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      stat_bursts_q <= 16'h0000;
      stat_errs_q   <= 16'h0000;
    end else if (state_q == DONE) begin
      if (stat_bursts_q != 16'hFFFF) stat_bursts_q <= stat_bursts_q + 16'h0001;
      if (burst_bad && (stat_errs_q != 16'hFFFF)) stat_errs_q <= stat_errs_q + 16'h0001;
    end
  end
`endif

endmodule : axi4_burst_master

// File: tb/tb_axi4_burst_master.sv
// Directed self-checking bench for axi4_burst_master.
module tb_axi4_burst_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic          ACLK;
  logic          ARESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic [2:0]    AWSIZE, ARSIZE;
  logic [1:0]    AWBURST, ARBURST;
  logic          AWVALID, AWREADY, ARVALID, ARREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  logic          WLAST, WVALID, WREADY;
  logic [1:0]    BRESP, RRESP;
  logic          BVALID, BREADY;
  logic          RLAST, RVALID, RREADY;
  logic          done, done_err;
  logic [1:0]    done_resp;
`ifdef AXI_BURST_MASTER_STATS_EN
  logic [15:0]   stat_bursts, stat_errs;
`endif

  int passed = 0;
  int total  = 0;
  logic [31:0] mem [0:255];

  axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .done(done), .done_resp(done_resp),
`ifdef AXI_BURST_MASTER_STATS_EN
    .done_err(done_err), .stat_bursts(stat_bursts), .stat_errs(stat_errs)
`else
    .done_err(done_err)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [7:0] l);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    #1 chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic finish_write(input logic [1:0] bresp);
    wr_valid = 1'b0; WREADY = 1'b0;
    BVALID = 1'b1; BRESP = bresp;
    #1 chk("bready", 64'(BREADY), 64'd1);
    step();
    BVALID = 1'b0;
    #1 chk("wr_done", 64'(done), 64'd1);
    chk("wr_done_resp", 64'(done_resp), 64'(bresp));
    step();
    #1 chk("wr_done_pulse_end", 64'(done), 64'd0);
    chk("wr_back_idle", 64'(cmd_ready), 64'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [7:0] l, input int nbeats,
                         input int last_idx, input int bad_idx, input logic [1:0] bad_resp,
                         input logic [31:0] exp_base, input logic [1:0] exp_resp,
                         input logic exp_err);
    logic [7:0] idx;
    issue_cmd(1'b0, a, l);
    chk("arvalid", 64'(ARVALID), 64'd1);
    chk("araddr", 64'(ARADDR), 64'(a));
    chk("arlen", 64'(ARLEN), 64'(l));
    chk("arsize", 64'(ARSIZE), 64'd2);
    chk("arburst", 64'(ARBURST), 64'd1);
    chk("awvalid_in_read", 64'(AWVALID), 64'd0);
    ARREADY = 1'b1;
    step();
    ARREADY = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      idx = 8'(a >> 2) + 8'(b);
      RVALID = 1'b1; RDATA = mem[idx];
      RLAST = (b == last_idx); RRESP = (b == bad_idx) ? bad_resp : 2'b00;
      rd_ready = 1'b1;
      #1 chk("rd_valid", 64'(rd_valid), 64'd1);
      chk("rd_data", 64'(rd_data), 64'(exp_base + 32'(b)));
      chk("rd_last", 64'(rd_last), 64'(b == last_idx));
      chk("rready", 64'(RREADY), 64'd1);
      step();
    end
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    #1 chk("rd_done", 64'(done), 64'd1);
    chk("rd_done_resp", 64'(done_resp), 64'(exp_resp));
    chk("rd_done_err", 64'(done_err), 64'(exp_err));
    step();
    #1 chk("rd_done_pulse_end", 64'(done), 64'd0);
    chk("rd_back_idle", 64'(cmd_ready), 64'd1);
    chk("rd_resp_hold", 64'(done_resp), 64'(exp_resp));
    chk("rd_err_hold", 64'(done_err), 64'(exp_err));
  endtask

  initial begin
    int hs;
    logic [7:0] vpat, rpat, idx;

    ARESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b1; wr_data = '0; rd_ready = 1'b1;
    AWREADY = 1'b0; WREADY = 1'b0; BRESP = 2'b00; BVALID = 1'b0;
    ARREADY = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    // reset state (wr_valid/RVALID held high to prove they are not passed through)
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_awvalid", 64'(AWVALID), 64'd0);
    chk("rst_arvalid", 64'(ARVALID), 64'd0);
    chk("rst_wvalid", 64'(WVALID), 64'd0);
    chk("rst_wlast", 64'(WLAST), 64'd0);
    chk("rst_bready", 64'(BREADY), 64'd0);
    chk("rst_rready", 64'(RREADY), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_done_resp", 64'(done_resp), 64'd0);
    chk("rst_done_err", 64'(done_err), 64'd0);
    RVALID = 1'b0;

    // Test 1: write len=3 at 0x010, data A0..A3, slave always ready
    issue_cmd(1'b1, 10'h010, 8'd3);
    chk("t1_awvalid", 64'(AWVALID), 64'd1);
    chk("t1_awaddr", 64'(AWADDR), 64'h010);
    chk("t1_awlen", 64'(AWLEN), 64'd3);
    chk("t1_awsize", 64'(AWSIZE), 64'd2);
    chk("t1_awburst", 64'(AWBURST), 64'd1);
    chk("t1_no_w_before_aw", 64'(WVALID), 64'd0);
    AWREADY = 1'b1;
    step();
    AWREADY = 1'b0;
    #1 chk("t1_awvalid_drop", 64'(AWVALID), 64'd0);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; WREADY = 1'b1; wr_data = 32'hA0 + 32'(i);
      #1 chk("t1_wvalid", 64'(WVALID), 64'd1);
      chk("t1_wdata", 64'(WDATA), 64'(32'hA0 + 32'(i)));
      chk("t1_wlast", 64'(WLAST), 64'(i == 3));
      chk("t1_wstrb", 64'(WSTRB), 64'hF);
      chk("t1_wr_ready", 64'(wr_ready), 64'd1);
      idx = 8'(10'h010 >> 2) + 8'(i);
      mem[idx] = WDATA;
      step();
    end
    finish_write(2'b00);

    // Test 2: read len=3 at 0x010 returns the written data
    do_read(10'h010, 8'd3, 4, 3, -1, 2'b00, 32'hA0, 2'b00, 1'b0);

    // Test 3: write with AWREADY low 5 cycles and handshake gaps
    wr_valid = 1'b1;
    issue_cmd(1'b1, 10'h020, 8'd3);
    for (int k = 0; k < 5; k++) begin
      chk("t3_awvalid_held", 64'(AWVALID), 64'd1);
      chk("t3_awaddr_stable", 64'(AWADDR), 64'h020);
      chk("t3_no_w_before_aw", 64'(WVALID), 64'd0);
      step();
      #1;
    end
    AWREADY = 1'b1;
    step();
    AWREADY = 1'b0;
    vpat = 8'b1011_0111;
    rpat = 8'b1101_1010;
    hs = 0;
    for (int c = 0; c < 40 && hs < 4; c++) begin
      wr_valid = vpat[3'(c)]; WREADY = rpat[3'(c)]; wr_data = 32'hB0 + 32'(hs);
      #1;
      if (WVALID && WREADY) begin
        chk("t3_wdata_order", 64'(WDATA), 64'(32'hB0 + 32'(hs)));
        chk("t3_wlast", 64'(WLAST), 64'(hs == 3));
        idx = 8'(10'h020 >> 2) + 8'(hs);
        mem[idx] = WDATA;
        hs++;
      end
      step();
    end
    chk("t3_w_handshakes", 64'(hs), 64'd4);
    wr_valid = 1'b1; WREADY = 1'b1;
    #1 chk("t3_no_extra_w", 64'(WVALID), 64'd0);
    finish_write(2'b00);

    // Test 4: read with SLVERR on beat 2 of 4
    do_read(10'h020, 8'd3, 4, 3, 1, 2'b10, 32'hB0, 2'b10, 1'b0);

    // Test 5: read len=3 with RLAST on beat 2
    do_read(10'h010, 8'd3, 2, 1, -1, 2'b00, 32'hA0, 2'b00, 1'b1);

`ifdef AXI_BURST_MASTER_STATS_EN
    chk("stat_bursts", 64'(stat_bursts), 64'd5);
    chk("stat_errs", 64'(stat_errs), 64'd2);
`endif

    // Test 6: reset asserted during write beat 2
    issue_cmd(1'b1, 10'h030, 8'd3);
    AWREADY = 1'b1;
    step();
    AWREADY = 1'b0;
    wr_valid = 1'b1; WREADY = 1'b1; wr_data = 32'hC0;
    #1 chk("t6_beat1", 64'(WVALID), 64'd1);
    step();
    wr_data = 32'hC1; ARESET = 1'b1;
    step();
    ARESET = 1'b0; RVALID = 1'b1;
    #1 chk("t6_awvalid", 64'(AWVALID), 64'd0);
    chk("t6_wvalid", 64'(WVALID), 64'd0);
    chk("t6_arvalid", 64'(ARVALID), 64'd0);
    chk("t6_bready", 64'(BREADY), 64'd0);
    chk("t6_rready", 64'(RREADY), 64'd0);
    chk("t6_rd_valid", 64'(rd_valid), 64'd0);
    chk("t6_wlast", 64'(WLAST), 64'd0);
    chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_done_err", 64'(done_err), 64'd0);
`ifdef AXI_BURST_MASTER_STATS_EN
    chk("t6_stat_bursts", 64'(stat_bursts), 64'd0);
    chk("t6_stat_errs", 64'(stat_errs), 64'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      step();
      #1 chk("t6_no_done", 64'(done), 64'd0);
    end
    RVALID = 1'b0; wr_valid = 1'b0; WREADY = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_axi4_burst_master
